// File: rtl/int_entry_unit.sv
// Interrupt entry/return sequencer: takes queued requests at instruction boundaries,
// saves the PC, redirects fetch to the vector and owns the user/system privilege bit.
module int_entry_unit #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        do_int,
    input  logic [15:0] int_addr,
    output logic        int_ack,
    output logic        priv_lv,
    input  logic        instr_boundary,
    input  logic [15:0] cur_pc,
    input  logic        rti,
    input  logic        syscall,
    output logic        swi,
    output logic [15:0] epc,
    output logic        pc_load,
    output logic [15:0] pc_load_addr,
    output logic        stall,
    output logic        ack_err
);

    localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAVE = 2'd1,
        ACK  = 2'd2,
        RET  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [15:0]        vec;
    logic [CNT_W-1:0]   ack_cnt;
    logic               take_int;
    logic               take_rti;
    logic               ack_expire;

    assign take_int   = priv_lv && do_int && instr_boundary;
    assign take_rti   = !priv_lv && rti;
    assign ack_expire = do_int && (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take_int) begin
                    state_nxt = SAVE;
                end else if (take_rti) begin
                    state_nxt = RET;
                end
            end
            SAVE: state_nxt = ACK;
            ACK: begin
                if (!do_int || ack_expire) begin
                    state_nxt = IDLE;
                end
            end
            RET:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall        = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = 16'h0000;
        int_ack      = 1'b0;
        case (state)
            SAVE: begin
                stall        = 1'b1;
                pc_load      = 1'b1;
                pc_load_addr = vec;
            end
            ACK: begin
                stall   = 1'b1;
                int_ack = 1'b1;
            end
            RET: begin
                stall        = 1'b1;
                pc_load      = 1'b1;
                pc_load_addr = epc;
            end
            default: ;
        endcase
    end

    // Privilege drops when leaving SAVE and rises on the edge that enters RET
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            priv_lv <= 1'b0;
            epc     <= 16'h0000;
            vec     <= 16'h0000;
            ack_cnt <= '0;
            ack_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_int) begin
                        epc <= cur_pc;
                        vec <= int_addr;
                    end else if (take_rti) begin
                        priv_lv <= 1'b1;
                    end
                end
                SAVE: begin
                    priv_lv <= 1'b0;
                    ack_cnt <= '0;
                end
                ACK: begin
                    ack_cnt <= ack_cnt + 1'b1;
                    if (ack_expire) begin
                        ack_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Software-interrupt pulse is decoupled from the entry sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swi <= 1'b0;
        end else begin
            swi <= syscall && priv_lv;
        end
    end

endmodule

// File: tb/tb_int_entry_unit.sv
// Directed bench for int_entry_unit: cycle table for the nominal flows plus
// hand sequences for boundary hold-off, ACK timeout and mid-ACK reset.
module tb_int_entry_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        do_int;
    logic [15:0] int_addr;
    logic        int_ack;
    logic        priv_lv;
    logic        instr_boundary;
    logic [15:0] cur_pc;
    logic        rti;
    logic        syscall;
    logic        swi;
    logic [15:0] epc;
    logic        pc_load;
    logic [15:0] pc_load_addr;
    logic        stall;
    logic        ack_err;

    int checks = 0;
    int failures = 0;

    int_entry_unit #(.ACK_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .do_int(do_int), .int_addr(int_addr),
        .int_ack(int_ack), .priv_lv(priv_lv), .instr_boundary(instr_boundary),
        .cur_pc(cur_pc), .rti(rti), .syscall(syscall), .swi(swi), .epc(epc),
        .pc_load(pc_load), .pc_load_addr(pc_load_addr), .stall(stall),
        .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        d;
        logic [15:0] a;
        logic        ib;
        logic [15:0] pc;
        logic        r;
        logic        sc;
        logic        ack;
        logic        priv;
        logic        sw;
        logic [15:0] e;
        logic        pl;
        logic [15:0] pla;
        logic        st;
    } vec_t;

    vec_t vt[18];

    function automatic vec_t mk(input logic d, input logic [15:0] a, input logic ib,
                                input logic [15:0] pc, input logic r, input logic sc,
                                input logic ack, input logic priv, input logic sw,
                                input logic [15:0] e, input logic pl,
                                input logic [15:0] pla, input logic st);
        vec_t t;
        t.d = d; t.a = a; t.ib = ib; t.pc = pc; t.r = r; t.sc = sc;
        t.ack = ack; t.priv = priv; t.sw = sw; t.e = e; t.pl = pl; t.pla = pla; t.st = st;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        do_int = 0; int_addr = 16'h0; instr_boundary = 0; cur_pc = 16'h0;
        rti = 0; syscall = 0;
    endtask

    logic [63:0] act_o;
    logic [63:0] exp_o;
    int n_ack;

    initial begin
        // {d, addr, ib, pc, rti, sc} -> {ack, priv, swi, epc, pl, pla, stall}
        vt[0]  = mk(0, 16'h0000, 0, 16'h0000, 1, 0,  0, 1, 0, 16'h0000, 1, 16'h0000, 1);
        vt[1]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0,  0, 1, 0, 16'h0000, 0, 16'h0000, 0);
        vt[2]  = mk(1, 16'h8000, 1, 16'h1234, 0, 0,  0, 1, 0, 16'h1234, 1, 16'h8000, 1);
        vt[3]  = mk(1, 16'h5555, 0, 16'h7777, 0, 0,  1, 0, 0, 16'h1234, 0, 16'h0000, 1);
        vt[4]  = mk(1, 16'h5555, 1, 16'h7777, 0, 0,  1, 0, 0, 16'h1234, 0, 16'h0000, 1);
        vt[5]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0,  0, 0, 0, 16'h1234, 0, 16'h0000, 0);
        vt[6]  = mk(0, 16'h0000, 0, 16'h0000, 0, 1,  0, 0, 0, 16'h1234, 0, 16'h0000, 0);
        vt[7]  = mk(1, 16'h6000, 1, 16'h4444, 1, 0,  0, 1, 0, 16'h1234, 1, 16'h1234, 1);
        vt[8]  = mk(1, 16'h9000, 1, 16'h2000, 0, 0,  0, 1, 0, 16'h1234, 0, 16'h0000, 0);
        vt[9]  = mk(1, 16'h9000, 1, 16'h2000, 0, 1,  0, 1, 1, 16'h2000, 1, 16'h9000, 1);
        vt[10] = mk(1, 16'h9000, 0, 16'h2000, 0, 0,  1, 0, 0, 16'h2000, 0, 16'h0000, 1);
        vt[11] = mk(1, 16'h9000, 0, 16'h2000, 0, 0,  1, 0, 0, 16'h2000, 0, 16'h0000, 1);
        vt[12] = mk(0, 16'h0000, 0, 16'h0000, 0, 0,  0, 0, 0, 16'h2000, 0, 16'h0000, 0);
        vt[13] = mk(0, 16'h0000, 0, 16'h0000, 1, 0,  0, 1, 0, 16'h2000, 1, 16'h2000, 1);
        vt[14] = mk(0, 16'h0000, 0, 16'h0000, 1, 0,  0, 1, 0, 16'h2000, 0, 16'h0000, 0);
        vt[15] = mk(0, 16'h0000, 0, 16'h0000, 1, 0,  0, 1, 0, 16'h2000, 0, 16'h0000, 0);
        vt[16] = mk(0, 16'h0000, 0, 16'h0000, 0, 1,  0, 1, 1, 16'h2000, 0, 16'h0000, 0);
        vt[17] = mk(0, 16'h0000, 0, 16'h0000, 0, 0,  0, 1, 0, 16'h2000, 0, 16'h0000, 0);

        rst_n = 0;
        idle_in();
        tick();
        tick();
        chk("reset_outputs", {int_ack, priv_lv, swi, pc_load, stall, ack_err},
            6'b000000);
        chk("reset_epc", epc, 16'h0);
        chk("reset_pla", pc_load_addr, 16'h0);
        rst_n = 1;
        tick();

        for (int i = 0; i < 18; i++) begin
            do_int = vt[i].d; int_addr = vt[i].a; instr_boundary = vt[i].ib;
            cur_pc = vt[i].pc; rti = vt[i].r; syscall = vt[i].sc;
            tick();
            act_o = {int_ack, priv_lv, swi, pc_load, stall, ack_err, epc, pc_load_addr};
            exp_o = {vt[i].ack, vt[i].priv, vt[i].sw, vt[i].pl, vt[i].st, 1'b0, vt[i].e, vt[i].pla};
            chk($sformatf("vec%0d", i), act_o, exp_o);
        end

        // do_int held without a boundary must not enter
        idle_in();
        do_int = 1; int_addr = 16'hA000; cur_pc = 16'h3000;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("noib_pl%0d", i), {pc_load, stall}, 2'b00);
        end
        instr_boundary = 1;
        tick();
        chk("ib_entry_pl", {pc_load, pc_load_addr}, {1'b1, 16'hA000});
        instr_boundary = 0;
        tick();
        tick();
        do_int = 0;
        tick();
        chk("ib_entry_done", {int_ack, stall, priv_lv, epc}, {3'b000, 16'h3000});
        rti = 1;
        tick();
        rti = 0;
        tick();
        chk("ib_back_user", {priv_lv, stall}, 2'b10);

        // ACK timeout with do_int stuck high
        do_int = 1; instr_boundary = 1; int_addr = 16'hB000; cur_pc = 16'h3100;
        tick();
        chk("to_save", {pc_load, pc_load_addr}, {1'b1, 16'hB000});
        instr_boundary = 0;
        n_ack = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (int_ack) n_ack++;
            else break;
        end
        chk("to_ack_cycles", n_ack, 15);
        chk("to_err_set", {ack_err, stall, priv_lv, pc_load}, 4'b1000);
        do_int = 0;
        tick();
        tick();
        chk("to_err_sticky", ack_err, 1'b1);
        rti = 1;
        tick();
        rti = 0;
        tick();
        chk("to_err_after_rti", {ack_err, priv_lv}, 2'b11);

        // asynchronous reset while in ACK
        do_int = 1; instr_boundary = 1; int_addr = 16'hC000; cur_pc = 16'h3200;
        tick();
        instr_boundary = 0;
        tick();
        chk("rst_in_ack", {int_ack, stall}, 2'b11);
        #2;
        rst_n = 0;
        #1;
        chk("rst_async_out", {int_ack, stall, pc_load, priv_lv, ack_err}, 5'b00000);
        chk("rst_async_epc", epc, 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1;
        do_int = 0;
        tick();
        chk("rst_release", {int_ack, stall, pc_load, priv_lv, ack_err, epc}, {5'b00000, 16'h0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
